bit_deserializer: RTL

//  - Serial-to-parallel capture stage directly downstream of the D flip-flop.
//  - Collects the flop's registered output one bit per qualified clock and

---
 rtl/bit_deserializer_pkg.sv | 12 +
 rtl/bit_deserializer_if.sv | 25 ++
 rtl/bit_deserializer_out_reg.sv | 54 +++++
 rtl/bit_deserializer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bit_deserializer_pkg.sv
// Shared types and defaults for the bit deserializer.
package dff_pkg;

    typedef enum logic [1:0] {
        S_SHIFT = 2'd0,
        S_PAR   = 2'd1,
        S_DONE  = 2'd2
    } deser_state_e;

    localparam int DESER_WIDTH_DEF = 8;

endpackage

// File: rtl/bit_deserializer_if.sv
// Serial-in / word-out handshake bundle for the bit deserializer.
// master: the environment (drives bits, accepts words); slave: the deserializer.
interface bit_deserializer_if
    import dff_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEF
);
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_data;
    logic             word_perr;

    modport master (
        output bit_valid, bit_in, word_ready,
        input  bit_ready, word_valid, word_data, word_perr
    );

    modport slave (
        input  bit_valid, bit_in, word_ready,
        output bit_ready, word_valid, word_data, word_perr
    );
endinterface

// File: rtl/bit_deserializer_out_reg.sv
// Valid/ready output holding register: keeps a word stable until the
// consumer takes it, and accepts a new word in the same cycle as a handshake.
module deser_out_reg
    import dff_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             perr_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_perr
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             perr_q,  perr_d;

    // Next-state: load wins over drain, otherwise a handshake empties the register.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        perr_d  = perr_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
            perr_d  = perr_in;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_perr  = perr_q;

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel capture stage: collects bits LSB first into WIDTH-bit
// words and presents them on a valid/ready port.
// Optional feature macro: DESER_PARITY_EN (adds a trailing even-parity bit
// per frame and reports word_perr).
//
// state   | meaning
// S_SHIFT | accepting data bits, count = index of next bit
// S_PAR   | accepting the parity bit (DESER_PARITY_EN only)
// S_DONE  | frame complete, waiting for the output register to be free
module bit_deserializer
    import dff_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               clk,
    input  logic               rst,
    bit_deserializer_if.slave  bus
);

    deser_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             bit_ready_q, bit_ready_d;
    logic             accept;
    logic             load;
    logic             out_valid;
    logic             out_free;
    logic             perr_calc;

`ifdef DESER_PARITY_EN
    logic             par_q, par_d;
    assign perr_calc = ^{shift_q, par_q};
`else
    assign perr_calc = 1'b0;
`endif

    assign accept   = bus.bit_valid && bit_ready_q;
    assign out_free = !out_valid || bus.word_ready;

    // FSM next-state, bit placement and counter.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        load    = 1'b0;
`ifdef DESER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_SHIFT: begin
                if (accept) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (count_q == CNT_W'(i)) begin
                            shift_d[i] = bus.bit_in;
                        end
                    end
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
`ifdef DESER_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef DESER_PARITY_EN
            S_PAR: begin
                if (accept) begin
                    par_d   = bus.bit_in;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_free) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = S_SHIFT;
                end
            end
            default: begin
                count_d = '0;
                state_d = S_SHIFT;
            end
        endcase
        bit_ready_d = (state_d != S_DONE);
    end

    // State, counter, shift register and registered bit_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_SHIFT;
            count_q     <= '0;
            shift_q     <= '0;
            bit_ready_q <= 1'b1;
`ifdef DESER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            bit_ready_q <= bit_ready_d;
`ifdef DESER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    deser_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data_in   (shift_q),
        .perr_in   (perr_calc),
        .out_ready (bus.word_ready),
        .out_valid (out_valid),
        .out_data  (bus.word_data),
        .out_perr  (bus.word_perr)
    );

    assign bus.word_valid = out_valid;
    assign bus.bit_ready  = bit_ready_q;

endmodule
